// File: rtl/adder_stream.sv
// adder_stream
//   Pipelined multi-lane adder/subtractor with valid/ready handshakes on both
//   sides. The arithmetic is done combinationally in front of stage 0. Stages
//   1..LATENCY-1 only carry the result forward. Bubbles collapse under
//   backpressure, so a stalled pipeline still fills to LATENCY beats.
//
// Optional build macro: ADDER_SATURATE_EN
//   When defined, any lane that flags overflow has its sum clamped instead of
//   wrapped. Unsigned lanes clamp to all-ones on carry and to zero on borrow.
//   Signed lanes clamp to max-positive or min-negative.
//   When undefined, sums always wrap and no clamp logic exists.
//
// Ports
//   aclk       clock, rising edge
//   arstn      asynchronous reset, active low
//   srst       synchronous reset, active high (same effect as arstn)
//   in_valid   input beat valid
//   in_ready   block can accept a beat (forced low during either reset)
//   in_sub     1 = a - b, 0 = a + b, for all lanes of the beat
//   in_a/in_b  operands, lane i at [i*WIDTH +: WIDTH]
//   out_valid  output beat valid
//   out_ready  consumer accepts the beat
//   out_sum    per-lane result, same packing as the operands
//   out_carry  per-lane carry (add) or borrow (sub)
//   out_ovf    per-lane signed overflow if SIGNED, else a copy of out_carry
module adder_stream #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int LANES   = 1,
  parameter bit SIGNED  = 1'b0
) (
  input  logic                   aclk,
  input  logic                   arstn,
  input  logic                   srst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sub,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_sum,
  output logic [LANES-1:0]       out_carry,
  output logic [LANES-1:0]       out_ovf
);

  logic [LANES*WIDTH-1:0] w_sum_in;
  logic [LANES-1:0]       w_carry_in;
  logic [LANES-1:0]       w_ovf_in;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH:0]   w_full;
    logic             w_c;
    logic             w_ov;

    assign w_a    = in_a[gi*WIDTH +: WIDTH];
    assign w_b    = in_b[gi*WIDTH +: WIDTH];
    // Subtract as a + ~b + 1, so the top bit of w_full is an inverted borrow.
    assign w_bx   = in_sub ? ~w_b : w_b;
    assign w_full = {1'b0, w_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, in_sub};
    assign w_c    = in_sub ? ~w_full[WIDTH] : w_full[WIDTH];

    if (SIGNED) begin : g_sgn
      // Overflow compares the sign of the effective addend (~b on subtract).
      // This covers the add rule and the subtract rule with one expression.
      assign w_ov = (w_a[WIDTH-1] == w_bx[WIDTH-1]) &&
                    (w_full[WIDTH-1] != w_a[WIDTH-1]);
    end else begin : g_uns
      assign w_ov = w_c;
    end

`ifdef ADDER_SATURATE_EN
    logic [WIDTH-1:0] w_clamp;
    if (SIGNED) begin : g_clamp_sgn
      // On signed overflow the true result has the sign of a.
      assign w_clamp = w_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin : g_clamp_uns
      assign w_clamp = in_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end
    assign w_s = w_ov ? w_clamp : w_full[WIDTH-1:0];
`else
    assign w_s = w_full[WIDTH-1:0];
`endif

    assign w_sum_in[gi*WIDTH +: WIDTH] = w_s;
    assign w_carry_in[gi]              = w_c;
    assign w_ovf_in[gi]                = w_ov;
  end

  logic [LATENCY-1:0]     r_v;
  logic [LANES*WIDTH-1:0] r_sum   [LATENCY];
  logic [LANES-1:0]       r_carry [LATENCY];
  logic [LANES-1:0]       r_ovf   [LATENCY];
  logic [LATENCY-1:0]     w_rdy;

  // Stage k can load unless every stage from k to the output is full
  // and the consumer is stalling. This is the flattened form of
  // ready_k = !v_k || ready_(k+1), and it avoids a combinational self-loop.
  always_comb begin
    w_rdy = '0;
    for (int k = 0; k < LATENCY; k++) begin
      w_rdy[k] = out_ready;
      for (int j = k; j < LATENCY; j++) begin
        if (!r_v[j]) w_rdy[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_v <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_sum[k]   <= '0;
        r_carry[k] <= '0;
        r_ovf[k]   <= '0;
      end
    end else if (srst) begin
      r_v <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        r_sum[k]   <= '0;
        r_carry[k] <= '0;
        r_ovf[k]   <= '0;
      end
    end else begin
      if (w_rdy[0]) begin
        r_v[0] <= in_valid;
        if (in_valid) begin
          r_sum[0]   <= w_sum_in;
          r_carry[0] <= w_carry_in;
          r_ovf[0]   <= w_ovf_in;
        end
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (w_rdy[k]) begin
          r_v[k] <= r_v[k-1];
          // The payload only moves with a valid beat, so an empty slot never
          // disturbs a held result.
          if (r_v[k-1]) begin
            r_sum[k]   <= r_sum[k-1];
            r_carry[k] <= r_carry[k-1];
            r_ovf[k]   <= r_ovf[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = w_rdy[0] && arstn && !srst;
  assign out_valid = r_v[LATENCY-1];
  assign out_sum   = r_sum[LATENCY-1];
  assign out_carry = r_carry[LATENCY-1];
  assign out_ovf   = r_ovf[LATENCY-1];

endmodule

// File: tb/tb_adder_stream.sv
// Bench for adder_stream with two instances:
//   u_a: WIDTH=8, LATENCY=3, LANES=1, SIGNED=0 (reset, latency, carry/borrow)
//   u_b: WIDTH=8, LATENCY=2, LANES=4, SIGNED=1 (backpressure, signed overflow)
// Inputs are driven at the falling edge. Handshakes are evaluated just after
// that, so each record describes the transfer at the following rising edge.
module tb_adder_stream;

`ifdef ADDER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic arstn, srst;

  logic        a_in_valid, a_in_ready, a_in_sub, a_out_valid, a_out_ready;
  logic [7:0]  a_in_a, a_in_b, a_out_sum;
  logic [0:0]  a_out_carry, a_out_ovf;

  logic        b_in_valid, b_in_ready, b_in_sub, b_out_valid, b_out_ready;
  logic [31:0] b_in_a, b_in_b, b_out_sum;
  logic [3:0]  b_out_carry, b_out_ovf;

  adder_stream #(.WIDTH(8), .LATENCY(3), .LANES(1), .SIGNED(1'b0)) u_a (
    .aclk(aclk), .arstn(arstn), .srst(srst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sub(a_in_sub),
    .in_a(a_in_a), .in_b(a_in_b),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_carry(a_out_carry), .out_ovf(a_out_ovf)
  );

  adder_stream #(.WIDTH(8), .LATENCY(2), .LANES(4), .SIGNED(1'b1)) u_b (
    .aclk(aclk), .arstn(arstn), .srst(srst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sub(b_in_sub),
    .in_a(b_in_a), .in_b(b_in_b),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_carry(b_out_carry), .out_ovf(b_out_ovf)
  );

  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;
  int idx;
  int n_seen;
  bit b_acc_now;

  logic [15:0] a_out_q[$];
  int          a_acc_cyc[$];
  int          a_out_cyc[$];
  logic [63:0] b_out_q[$];
  logic [15:0] exp16;
  logic [63:0] got64;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Record the handshakes for the coming edge, then advance to the next falling edge.
  task automatic tick();
    #1;
    if (a_in_valid && a_in_ready) a_acc_cyc.push_back(cyc);
    if (a_out_valid && a_out_ready) begin
      a_out_q.push_back({6'h0, a_out_ovf, a_out_carry, a_out_sum});
      a_out_cyc.push_back(cyc);
    end
    b_acc_now = b_in_valid && b_in_ready;
    if (b_out_valid && b_out_ready)
      b_out_q.push_back({24'h0, b_out_ovf, b_out_carry, b_out_sum});
    @(negedge aclk);
    cyc++;
  endtask

  task automatic clear_q();
    a_out_q.delete(); a_acc_cyc.delete(); a_out_cyc.delete(); b_out_q.delete();
  endtask

  initial begin
    arstn = 1'b1; srst = 1'b0;
    a_in_valid = 1'b1; a_in_sub = 1'b0; a_in_a = 8'd1; a_in_b = 8'd1; a_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_sub = 1'b0; b_in_a = 32'd1; b_in_b = 32'd1; b_out_ready = 1'b1;
    #1 arstn = 1'b0;

    // Reset held for 3 cycles while both sources offer data.
    repeat (3) begin
      @(negedge aclk); #1;
      chk("rst_a_out_valid", a_out_valid, 0);
      chk("rst_a_in_ready", a_in_ready, 0);
      chk("rst_b_in_ready", b_in_ready, 0);
    end
    @(negedge aclk);
    arstn = 1'b1; a_in_valid = 1'b0; b_in_valid = 1'b0;
    #1;
    chk("rel_a_in_ready", a_in_ready, 1);
    chk("rel_b_in_ready", b_in_ready, 1);
    chk("rel_a_out_valid", a_out_valid, 0);

    // Put two beats in flight, then apply a one-cycle synchronous reset.
    clear_q();
    a_in_valid = 1'b1; a_in_a = 8'd1; a_in_b = 8'd1; tick();
    a_in_a = 8'd2; tick();
    a_in_valid = 1'b0; srst = 1'b1; #1;
    chk("srst_in_ready", a_in_ready, 0);
    tick();
    srst = 1'b0;
    repeat (8) tick();
    chk("srst_accepted", a_acc_cyc.size(), 2);
    chk("srst_no_emit", a_out_q.size(), 0);

    // Ten back-to-back beats with a=i and b=2i at latency 3.
    clear_q();
    for (int i = 0; i < 10; i++) begin
      a_in_valid = 1'b1; a_in_sub = 1'b0; a_in_a = 8'(i); a_in_b = 8'(2 * i);
      tick();
    end
    a_in_valid = 1'b0;
    repeat (6) tick();
    chk("thr_accepts", a_acc_cyc.size(), 10);
    chk("thr_emits", a_out_q.size(), 10);
    if (a_acc_cyc.size() > 0 && a_out_cyc.size() > 0)
      chk("lat_first", a_out_cyc[0] - a_acc_cyc[0], 3);
    else
      chk("lat_first_missing", 0, 1);
    if (a_out_cyc.size() == 10) chk("thr_back_to_back", a_out_cyc[9] - a_out_cyc[0], 9);
    for (int i = 0; i < 10; i++) begin
      exp16 = {8'h00, 8'(3 * i)};
      chk($sformatf("thr_sum%0d", i), (i < a_out_q.size()) ? a_out_q[i] : 16'hFFFF, exp16);
    end

    // Unsigned carry and borrow. Each queue entry packs {ovf, carry, sum}.
    clear_q();
    a_in_valid = 1'b1;
    a_in_sub = 1'b0; a_in_a = 8'd200; a_in_b = 8'd100; tick();
    a_in_sub = 1'b1; a_in_a = 8'd5;   a_in_b = 8'd7;   tick();
    a_in_sub = 1'b1; a_in_a = 8'd7;   a_in_b = 8'd5;   tick();
    a_in_valid = 1'b0; a_in_sub = 1'b0;
    repeat (6) tick();
    chk("cb_emits", a_out_q.size(), 3);
    exp16 = {6'h0, 2'b11, SAT ? 8'd255 : 8'd44};
    chk("cb_200p100", (a_out_q.size() > 0) ? a_out_q[0] : 16'hFFFF, exp16);
    exp16 = {6'h0, 2'b11, SAT ? 8'd0 : 8'd254};
    chk("cb_5m7", (a_out_q.size() > 1) ? a_out_q[1] : 16'hFFFF, exp16);
    exp16 = {6'h0, 2'b00, 8'd2};
    chk("cb_7m5", (a_out_q.size() > 2) ? a_out_q[2] : 16'hFFFF, exp16);

    // Backpressure on the latency-2 instance: lane0 beat k is (3k+1)+7.
    clear_q();
    idx = 0;
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_in_a = {24'h0, 8'(3 * idx + 1)}; b_in_b = 32'd7;
      tick();
      if (b_acc_now) idx++;
      if (i == 2) chk("bp_hold_mid", b_out_sum, 32'd8);
    end
    #1;
    chk("bp_fill", idx, 2);
    chk("bp_in_ready_low", b_in_ready, 0);
    chk("bp_out_valid", b_out_valid, 1);
    chk("bp_hold_end", b_out_sum, 32'd8);
    for (int i = 0; i < 20; i++) begin
      b_out_ready = (i % 2 == 0);
      b_in_a = {24'h0, 8'(3 * idx + 1)}; b_in_b = 32'd7;
      tick();
      if (b_acc_now) idx++;
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    repeat (6) tick();
    chk("bp_progress", idx >= 10, 1);
    chk("bp_count", b_out_q.size(), idx);
    n_seen = (b_out_q.size() < idx) ? b_out_q.size() : idx;
    for (int k = 0; k < n_seen; k++)
      chk($sformatf("bp_order%0d", k), b_out_q[k], {32'h0, 24'h0, 8'(3 * k + 8)});

    // Signed overflow across 4 lanes: one add beat, then one subtract beat.
    clear_q();
    b_in_valid = 1'b1;
    b_in_sub = 1'b0; b_in_a = 32'h32809C64; b_in_b = 32'hECFF9C64; tick();
    b_in_sub = 1'b1; b_in_a = 32'h32809C64; b_in_b = 32'h1401649C; tick();
    b_in_valid = 1'b0; b_in_sub = 1'b0;
    repeat (5) tick();
    chk("sg_emits", b_out_q.size(), 2);
    got64 = (b_out_q.size() > 0) ? b_out_q[0] : 64'hFFFF_FFFF_FFFF_FFFF;
    chk("sg_add_sum", got64[31:0], SAT ? 32'h1E80807F : 32'h1E7F38C8);
    chk("sg_add_carry", got64[35:32], 4'b1110);
    chk("sg_add_ovf", got64[39:36], 4'b0111);
    got64 = (b_out_q.size() > 1) ? b_out_q[1] : 64'hFFFF_FFFF_FFFF_FFFF;
    chk("sg_sub_sum", got64[31:0], SAT ? 32'h1E80807F : 32'h1E7F38C8);
    chk("sg_sub_carry", got64[35:32], 4'b0001);
    chk("sg_sub_ovf", got64[39:36], 4'b0111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
